// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path (and the planned transmitter).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int SAMPLE_MID = 8;

    // Clock cycles per oversample tick; integer division truncates.
    function automatic int div_calc(input int clk_freq, input int baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery interface between the UART receiver and its consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase-resettable via clr.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote, valid/ready byte output
// with single-cycle framing and overrun error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUT_RATE = 115200
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      UART_RXD,
    uart_rx_if.master rx
);

    localparam int DIV = div_calc(CLK_FREQ, BAUT_RATE);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx: CLK_FREQ/(BAUT_RATE*16) must be at least 2");
    end

    localparam logic [3:0] SCNT_A    = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] SCNT_B    = 4'(SAMPLE_MID);
    localparam logic [3:0] SCNT_DEC  = 4'(SAMPLE_MID + 1);
    localparam logic [3:0] SCNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 rxd_m, rxd_s;
    logic                 tick, clr;
    logic [3:0]           scnt;
    logic [2:0]           bit_idx;
    logic                 samp_a, samp_b, maj;
    logic                 bit_decide, bit_end;
    logic                 shift_en, byte_done, frame_det;
    logic [DATA_BITS-1:0] shreg;
    rx_state_e            state, state_nxt;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, frame_err_q, overrun_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= UART_RXD;
            rxd_s <= rxd_m;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (clr),
        .tick (tick)
    );

    // Third sample is the live line value on the deciding tick.
    assign maj        = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);
    assign bit_decide = tick && (scnt == SCNT_DEC);
    assign bit_end    = tick && (scnt == SCNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rxd_s) state_nxt = START;
            START: begin
                if (bit_decide && maj)  state_nxt = IDLE;
                else if (bit_end)       state_nxt = DATA;
            end
            DATA:    if (bit_end && bit_idx == BIT_LAST) state_nxt = STOP;
            STOP:    if (bit_decide) state_nxt = maj ? IDLE : BREAK;
            BREAK:   if (rxd_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr       = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        frame_det = 1'b0;
        case (state)
            IDLE:    clr       = !rxd_s;
            DATA:    shift_en  = bit_decide;
            STOP: begin
                byte_done = bit_decide && maj;
                frame_det = bit_decide && !maj;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scnt    <= '0;
            bit_idx <= '0;
            samp_a  <= 1'b0;
            samp_b  <= 1'b0;
            shreg   <= '0;
        end else begin
            if (clr) begin
                scnt <= '0;
            end else if (tick) begin
                scnt <= (scnt == SCNT_LAST) ? 4'd0 : scnt + 4'd1;
            end

            if (state == START && bit_end) begin
                bit_idx <= '0;
            end else if (state == DATA && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (tick && scnt == SCNT_A) samp_a <= rxd_s;
            if (tick && scnt == SCNT_B) samp_b <= rxd_s;

            if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
        end
    end

    // A completion may coincide with an accept: the new byte replaces the old with no gap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_det;
            overrun_q   <= byte_done && valid_q && !rx.rx_ready;
            if (byte_done && (!valid_q || rx.rx_ready)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && rx.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Receives asynchronous 8N1 serial data on UART_RXD and delivers bytes on a valid/ready interface to the logic inside fpga_top.
It sits directly behind the board pin, upstream of the byte consumer (loopback/command logic) in fpga_top.
It uses 16x oversampling with majority-vote bit decisions and reports framing and overrun errors as single-cycle pulses.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUT_RATE, 115200, serial bit rate in baud.
- Derived constant DIV = CLK_FREQ/(BAUT_RATE*16), integer division, so 27 at the defaults.
- DIV must be at least 2; elaboration fails otherwise.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RST  input  1  synchronous active-high reset.
UART_RXD  input  1  asynchronous serial line; idles high.
rx_data  output  8  received byte; stable while rx_valid=1.
rx_valid  output  1  byte available; held high until accepted.
rx_ready  input  1  consumer accepts the byte on a cycle where rx_valid&&rx_ready.
frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
overrun  output  1  one-cycle pulse when a completed byte is dropped.

Behaviour:
- Interface rule (already decided): one clock, CLK; reset RST is synchronous and active-high.
- Reset values:
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
- Input path: 2-flop synchronizer gives rxd_s, which is the only version of the line used internally.
- Tick generator:
  - Free-running counter 0..DIV-1; tick asserts for one cycle when the count equals DIV-1.
  - The counter is reset to 0 on entry to START, so sampling phase is aligned to the start edge.
- Sampling within a bit:
  - scnt counts ticks 0..15 inside each bit.
  - rxd_s is captured at scnt 7, 8 and 9.
  - The bit value is the majority of the three captures, decided at scnt 9.
- IDLE: when rxd_s=0, go to START with scnt=0.
- START:
  - Majority=1 at scnt 9: false start, return to IDLE. No output.
  - Majority=0: wait until scnt 15, then go to DATA with bit index 0.
- DATA:
  - 8 bits, LSB first, shifted into the shift register at scnt 9.
  - After bit 7 reaches scnt 15, go to STOP.
- STOP, decided at scnt 9, leaving early so the next start edge can be caught with up to about 3% baud error:
  - Majority=1: byte complete, go to IDLE.
  - Majority=0: pulse frame_err, discard the byte, go to BREAK.
- BREAK: wait until rxd_s=1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Output register on byte completion, at cycle T = the cycle after the stop-bit scnt-9 tick:
  - If rx_valid=0, or rx_valid&&rx_ready in the same cycle: load rx_data and set rx_valid=1 at T. The accept and the new load happen together with no gap and no overrun.
  - If rx_valid=1 && rx_ready=0: keep the old rx_data, pulse overrun at T, and drop the new byte.
- Accept: rx_valid&&rx_ready with no completion in that cycle clears rx_valid on the next cycle.
- Latency: the start falling edge on the pin to rx_valid is about 9.56 bit periods + 3 cycles.
- Reset mid-frame: everything returns to reset values immediately, and any partial byte is discarded.
- frame_err and overrun are never asserted in the same cycle.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - OVERSAMPLE=16, DATA_BITS=8, SAMPLE_MID=8;
  - a function div_calc(CLK_FREQ, BAUT_RATE) that returns DIV.
- One sub-module, uart_baud_tick:
  - parameter DIV; ports CLK, RST, clr, tick;
  - reusable by the planned uart_tx, which must be instantiated with clr tied to 0.

Test Plan:
- Send 0x55, then 0xA3, at 115200 baud (8680 ns/bit), with rx_ready=1 -> two rx_valid pulses carrying rx_data 0x55 then 0xA3; frame_err=0; overrun=0.
- 2 µs low glitch on UART_RXD -> START rejects it; no rx_valid and no frame_err; the next real 0x3C is received correctly.
- Frame 0x81 with the stop bit driven low, then the line held low for 5 bit times -> exactly one frame_err pulse; no rx_valid; the following 0x7E is received.
- Bytes 0xA5 then 0x5A back-to-back with rx_ready=0 -> rx_data stays 0xA5 with rx_valid=1; one overrun pulse about 10 bit times after the first byte; raising rx_ready clears rx_valid.
- Assert RST for 1 cycle during bit 4 of 0xFF, then send 0x12 -> no output for the aborted frame; 0x12 is received.
- Transmit 0xC6 at +2% and at -2% baud -> 0xC6 is received both times with no errors.
